// File: rtl/conv_2d_coef_loader.sv
// Frame-synchronous coefficient loader: keeps a shadow copy of the convolution kernel and streams
// it into the datapath's inactive bank at a frame boundary, then requests a bank swap.
module conv_2d_coef_loader #(
   parameter  int COEF_WIDTH       = 13,
   parameter  int COEF_FRACT_WIDTH = 8,
   parameter  int WIN_SIZE         = 5,
   parameter  int SYNC_TO_FRAME    = 1,
   localparam int COEF_NUM         = WIN_SIZE * WIN_SIZE,
   localparam int AW               = $clog2(COEF_NUM)
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  cfg_wr_i,
   input  logic [AW-1:0]         cfg_addr_i,
   input  logic [COEF_WIDTH-1:0] cfg_data_i,
   input  logic                  cfg_commit_i,
   output logic                  cfg_busy_o,
   output logic                  cfg_drop_o,
   input  logic                  video_tvalid_i,
   input  logic                  video_tuser_i,
   output logic                  video_hold_o,
   output logic                  coef_wr_o,
   output logic [AW-1:0]         coef_addr_o,
   output logic [COEF_WIDTH-1:0] coef_data_o,
   output logic                  coef_swap_o
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_PENDING = 2'd1;
   localparam logic [1:0] ST_LOAD    = 2'd2;
   localparam logic [1:0] ST_SWAP    = 2'd3;

   localparam logic [AW:0]           NUM_W    = (AW+1)'(COEF_NUM);
   localparam logic [AW-1:0]         LAST_IDX = AW'(COEF_NUM - 1);
   localparam logic [COEF_WIDTH-1:0] IDENTITY = COEF_WIDTH'(1 << COEF_FRACT_WIDTH);

   logic [1:0]            state;
   logic [COEF_WIDTH-1:0] shadow [COEF_NUM];
   logic                  hold_q;

   logic                  busy;
   logic                  addr_ok;
   logic                  shadow_wr;
   logic                  sof;
   logic                  start_load;
   logic                  drop_d;
   logic [AW-1:0]         next_idx;
   logic [COEF_WIDTH-1:0] first_data;

   assign busy       = (state != ST_IDLE);
   assign addr_ok    = ({1'b0, cfg_addr_i} < NUM_W);
   assign shadow_wr  = cfg_wr_i & ~busy & addr_ok;
   assign sof        = video_tvalid_i & video_tuser_i;
   assign start_load = ((state == ST_IDLE) & cfg_commit_i & (SYNC_TO_FRAME == 0))
                     | ((state == ST_PENDING) & sof);
   assign drop_d     = (busy & (cfg_wr_i | cfg_commit_i)) | (~busy & cfg_wr_i & ~addr_ok);
   assign next_idx   = coef_addr_o + AW'(1);

   // An immediate load launched in the same cycle as a write to entry 0 must see the new value.
   assign first_data = (shadow_wr && cfg_addr_i == '0) ? cfg_data_i : shadow[0];

   assign cfg_busy_o   = busy;
   // The SOF beat must be refused in the very cycle it appears, hence the combinational term.
   assign video_hold_o = hold_q | ((state == ST_PENDING) & sof);

   // NOTE: the shadow is reset on purpose; its reset value is the identity kernel, not don't-care.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < COEF_NUM; i++) begin
            shadow[i] <= (i == COEF_NUM / 2) ? IDENTITY : '0;
         end
      end else if (shadow_wr) begin
         shadow[cfg_addr_i] <= cfg_data_i;
      end
   end

   // NOTE: all state and registered outputs use non-blocking assignments so every reader sees
   // the pre-edge value regardless of block evaluation order.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state       <= ST_IDLE;
         hold_q      <= 1'b0;
         cfg_drop_o  <= 1'b0;
         coef_wr_o   <= 1'b0;
         coef_addr_o <= '0;
         coef_data_o <= '0;
         coef_swap_o <= 1'b0;
      end else begin
         cfg_drop_o <= drop_d;
         if (start_load) begin
            state       <= ST_LOAD;
            hold_q      <= 1'b1;
            coef_wr_o   <= 1'b1;
            coef_addr_o <= '0;
            coef_data_o <= first_data;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (cfg_commit_i) begin
                     state <= ST_PENDING;
                  end
               end
               ST_LOAD: begin
                  if (coef_addr_o == LAST_IDX) begin
                     state       <= ST_SWAP;
                     coef_wr_o   <= 1'b0;
                     coef_swap_o <= 1'b1;
                  end else begin
                     coef_addr_o <= next_idx;
                     coef_data_o <= shadow[next_idx];
                  end
               end
               ST_SWAP: begin
                  state       <= ST_IDLE;
                  hold_q      <= 1'b0;
                  coef_swap_o <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/conv_2d_coef_loader.md
Name: conv_2d_coef_loader

Overview:
- Frame-synchronous coefficient controller for the 2D convolution datapath.
- Holds a shadow copy of the WIN_SIZE x WIN_SIZE kernel, written from the CSR side. On commit, it waits for the next start-of-frame beat, stalls the input stream, and serially streams the kernel into the datapath's inactive bank, then pulses a bank swap.
- Guarantees a kernel change never lands mid-frame.

Parameters:
- COEF_WIDTH, 13, signed coefficient width.
- COEF_FRACT_WIDTH, 8, fractional bits; used for the identity-kernel reset value.
- WIN_SIZE, 5, kernel side; COEF_NUM = WIN_SIZE*WIN_SIZE.
- SYNC_TO_FRAME, 1, 1 = load at next SOF; 0 = load immediately after commit.
- Derived: AW = $clog2(COEF_NUM).

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- cfg_wr_i  in  1  shadow write strobe
- cfg_addr_i  in  AW  shadow index, row-major
- cfg_data_i  in  COEF_WIDTH  coefficient
- cfg_commit_i  in  1  request apply of shadow kernel
- cfg_busy_o  out  1  commit pending or load in progress
- cfg_drop_o  out  1  one-cycle pulse: write or commit rejected
- video_tvalid_i  in  1  upstream tvalid (observed only)
- video_tuser_i  in  1  upstream tuser/SOF (observed only)
- video_hold_o  out  1  forces upstream tready low when 1
- coef_wr_o  out  1  datapath inactive-bank write strobe
- coef_addr_o  out  AW  datapath write index
- coef_data_o  out  COEF_WIDTH  datapath write data
- coef_swap_o  out  1  one-cycle pulse: datapath swaps banks

Behaviour:
- Reset values, asynchronous on rstn_i low:
  - all outputs 0, state IDLE;
  - shadow[COEF_NUM/2] = 1<<COEF_FRACT_WIDTH (identity kernel), all other shadow entries 0.
- States: IDLE, PENDING, LOAD, SWAP.
- IDLE:
  - cfg_wr_i with cfg_addr_i < COEF_NUM writes shadow at the clock edge.
  - cfg_addr_i >= COEF_NUM: write ignored, cfg_drop_o pulses next cycle.
  - cfg_commit_i -> PENDING if SYNC_TO_FRAME=1, else -> LOAD.
  - Same-cycle cfg_wr_i and cfg_commit_i: the write is applied first, and the committed kernel includes it.
- PENDING:
  - video_hold_o = video_tvalid_i & video_tuser_i, combinational, so the SOF beat is never accepted.
  - -> LOAD on the first cycle with video_tvalid_i & video_tuser_i.
  - video_tuser_i without video_tvalid_i is ignored.
- LOAD:
  - video_hold_o = 1, registered.
  - Index counter runs 0..COEF_NUM-1, one entry per cycle.
  - coef_wr_o = 1, coef_addr_o = idx, coef_data_o = shadow[idx], all registered.
  - After idx COEF_NUM-1 -> SWAP.
- SWAP:
  - coef_swap_o = 1 for exactly one cycle, video_hold_o = 1, coef_wr_o = 0.
  - -> IDLE; video_hold_o deasserts the following cycle.
- Latency: SOF seen in PENDING -> first coef_wr_o next cycle -> swap at cycle COEF_NUM+1 -> hold released at cycle COEF_NUM+2. Total stall = COEF_NUM+2 cycles (27 for WIN_SIZE=5).
- cfg_busy_o = 1 in PENDING, LOAD, SWAP.
- While busy:
  - cfg_wr_i and cfg_commit_i are rejected: shadow unchanged, cfg_drop_o pulses.
  - The shadow is therefore stable during LOAD.
- Repeated commits before SOF produce a single load (the second is a drop).
- Reset mid-LOAD: state returns to IDLE immediately, and outputs and shadow take reset values. No coef_swap_o is issued, so the datapath keeps its old active bank. The partially written inactive bank is harmless.
- Shadow coefficients are stored and forwarded bit-exact; no saturation or sign handling occurs here.

Test Plan:
- Reset check: after reset, commit with SYNC_TO_FRAME=0 and no writes -> 25 writes; addr 12 data 0x100, all others 0; swap at cycle 26.
- Shadow write and frame sync: write addr 0..24 with data = addr+1, commit; stream pixels with tuser=0 -> hold_o stays 0. Present tvalid=1,tuser=1 -> hold_o=1 same cycle; coef_wr_o sequence addr 0..24, data 1..25; swap one cycle; hold_o low 27 cycles after SOF; the SOF beat is accepted afterwards.
- Busy rejection: during PENDING, write addr 3 data 0x7FF and commit -> two cfg_drop_o pulses; loaded data for addr 3 is the old value; exactly one swap.
- Bad address: write addr 25 in IDLE -> cfg_drop_o pulse; shadow unchanged (verified by a subsequent load).
- Simultaneous write and commit: write addr 7 data 0x1F00 with commit in the same cycle -> loaded addr 7 = 0x1F00.
- Reset mid-load: assert rstn_i low at load idx 10 -> all outputs 0 asynchronously, no swap. After release, IDLE with cfg_busy_o=0 and identity shadow.
